// File: rtl/trace_pkg.sv
// trace_pkg: shared types and sizing helpers for the trace buffer.
// Provides the buffer FSM state enum, the default buffer depth,
// the pointer-width helper and the matching default pointer-width localparam.
package trace_pkg;

    typedef enum logic [1:0] {IDLE, DUMP, DONE} trace_buf_state_t;

    localparam int DEFAULT_BUFFER_SIZE = 16;

    function automatic int ptr_width(input int size);
        return $clog2(size);
    endfunction

    localparam int PTR_W = ptr_width(DEFAULT_BUFFER_SIZE);

endpackage

// File: rtl/trace_mem.sv
// trace_mem: DEPTH x N x DATA_WIDTH register array, one synchronous write
// port and one combinational read port; no reset.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module trace_mem
    import trace_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_BUFFER_SIZE,
    localparam int AW        = ptr_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [N-1:0][DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                raddr,
    output logic [N-1:0][DATA_WIDTH-1:0] rdata
);

    logic [N-1:0][DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: captures packed trace vectors into a circular buffer while
// tracing, then dumps them oldest-first over a valid/ready port.
// Ports: clk, reset (sync, active-high); tracing, valid_in, vector_in capture
// side; dump_req, out_ready, vector_out, out_valid, out_last, dump_done
// readout side; count/full occupancy status.
// Build option: TRACE_BUFFER_WRAP_EN selects overwrite-oldest when full;
// without it writes are dropped once full.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tracing,
    input  logic                            valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]    vector_in,
    input  logic                            dump_req,
    input  logic                            out_ready,
    output logic [N-1:0][DATA_WIDTH-1:0]    vector_out,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            dump_done,
    output logic [$clog2(BUFFER_SIZE):0]    count,
    output logic                            full
);

    localparam int PW = ptr_width(BUFFER_SIZE);

    trace_buf_state_t state, next_state;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] remaining;
    logic [N-1:0][DATA_WIDTH-1:0] rd_data;
    logic wr_en, start, hs;

    assign full = count == (PW+1)'(BUFFER_SIZE);
`ifdef TRACE_BUFFER_WRAP_EN
    assign wr_en = state == IDLE && valid_in && tracing;
`else
    assign wr_en = state == IDLE && valid_in && tracing && !full;
`endif
    assign start = state == IDLE && dump_req && !tracing;
    assign hs    = state == DUMP && out_ready;

    trace_mem #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .DEPTH(BUFFER_SIZE)
    ) u_mem (
        .clk(clk), .we(wr_en), .waddr(wr_ptr), .wdata(vector_in),
        .raddr(rd_ptr), .rdata(rd_data)
    );

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = count == '0 ? DONE : DUMP;
            DUMP:    if (hs && remaining == 1) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid  = state == DUMP;
        out_last   = out_valid && remaining == 1;
        dump_done  = state == DONE;
        vector_out = out_valid ? rd_data : '0;
    end

    // When full, count's low bits are zero so the oldest entry is wr_ptr itself.
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!full) count <= count + 1'b1;
            end
            if (start) begin
                rd_ptr    <= wr_ptr - count[PW-1:0];
                remaining <= count;
            end
            if (hs) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == DONE) begin
                count  <= '0;
                wr_ptr <= '0;
            end
        end

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed and randomized checks of trace_buffer against a queue model.
module tb_trace_buffer;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int SZ = 16;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic clk = 0, reset = 1, tracing = 0, valid_in = 0, dump_req = 0, out_ready = 0;
    vec_t vector_in = '0, vector_out;
    logic out_valid, out_last, dump_done, full;
    logic [4:0] count;

    int checks = 0, errors = 0;
    vec_t model[$];

    always #5 clk = ~clk;

    trace_buffer #(.N(N), .DATA_WIDTH(DW), .BUFFER_SIZE(SZ)) dut (
        .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
        .vector_in(vector_in), .dump_req(dump_req), .out_ready(out_ready),
        .vector_out(vector_out), .out_valid(out_valid), .out_last(out_last),
        .dump_done(dump_done), .count(count), .full(full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t splat(input int x);
        vec_t v;
        for (int l = 0; l < N; l++) v[l] = x[DW-1:0];
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int l = 0; l < N; l++) v[l] = $urandom;
        return v;
    endfunction

    task automatic model_write(input vec_t v);
        if (model.size() < SZ) model.push_back(v);
        else begin
`ifdef TRACE_BUFFER_WRAP_EN
            void'(model.pop_front());
            model.push_back(v);
`endif
        end
    endtask

    task automatic wr(input vec_t v, input bit en);
        tracing = 1;
        valid_in = en;
        vector_in = v;
        step();
        valid_in = 0;
        if (en) model_write(v);
        chk("count", count, model.size());
        chk("full", full, model.size() == SZ);
    endtask

    task automatic dump(input logic [15:0] pat, input bit rnd);
        int idx = 0, cyc = 0, n = model.size();
        tracing = 0;
        valid_in = 0;
        dump_req = 1;
        step();
        dump_req = 0;
        if (n == 0) begin
            chk("empty_done", dump_done, 1);
            chk("empty_valid", out_valid, 0);
            step();
            chk("empty_done_pulse", dump_done, 0);
            chk("empty_valid_after", out_valid, 0);
            chk("empty_count", count, 0);
            return;
        end
        while (idx < n && cyc < 200) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_data", vector_out, model[idx]);
            chk("beat_last", out_last, idx == n - 1);
            chk("beat_done_low", dump_done, 0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 16];
            tracing = 1'($urandom);
            valid_in = 1'($urandom);
            vector_in = rnd_vec();
            step();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 0;
        valid_in = 0;
        tracing = 0;
        chk("beat_total", idx, n);
        chk("dump_done", dump_done, 1);
        chk("valid_at_done", out_valid, 0);
        step();
        chk("done_pulse", dump_done, 0);
        chk("count_cleared", count, 0);
        model.delete();
    endtask

    initial begin
        reset = 1;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_vec", vector_out, 0);
        reset = 0;

        for (int i = 0; i < 5; i++) wr(splat(32'h10 + i), 1);
        dump(16'hFFFF, 0);

        for (int i = 0; i < 3; i++) wr(rnd_vec(), 1);
        tracing = 1;
        dump_req = 1;
        step();
        dump_req = 0;
        chk("ign_valid", out_valid, 0);
        chk("ign_done", dump_done, 0);
        chk("ign_count", count, 3);
        vector_in = splat(32'h77);
        valid_in = 1;
        dump_req = 1;
        step();
        valid_in = 0;
        dump_req = 0;
        model_write(splat(32'h77));
        chk("simul_count", count, 4);
        chk("simul_valid", out_valid, 0);
        dump(16'hFFFF, 0);

        for (int i = 0; i < 3; i++) wr(splat(32'hA0 + i), 1);
        dump(16'hFFF9, 0);

        dump(16'hFFFF, 0);

        for (int i = 0; i < 20; i++) wr(splat(i), 1);
        chk("full_before_dump", full, 1);
        dump(16'hFFFF, 0);

        for (int i = 0; i < 6; i++) wr(splat(32'h50 + i), 1);
        tracing = 0;
        dump_req = 1;
        step();
        dump_req = 0;
        out_ready = 1;
        chk("mid_beat0", vector_out, splat(32'h50));
        step();
        chk("mid_beat1", vector_out, splat(32'h51));
        step();
        out_ready = 0;
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_done", dump_done, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_vec", vector_out, 0);
        step();
        chk("mid_rst_no_done", dump_done, 0);
        model.delete();
        dump(16'hFFFF, 0);

        for (int r = 0; r < 6; r++) begin
            int k = $urandom_range(0, 22);
            for (int i = 0; i < k; i++) wr(rnd_vec(), $urandom_range(0, 3) != 0);
            dump(16'h0000, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Captures packed N-wide trace vectors from the data packer stage into a circular on-chip buffer while tracing is active, then dumps the stored vectors oldest-first over a valid/ready readout port once tracing stops. It sits directly downstream of the packer (its `valid_in`/`vector_in` are the packer's `valid_out`/`vector_out`) and upstream of the host readout interface.

## Interface
- `N`, 8, vector lanes; must equal the packer's N
- `DATA_WIDTH`, 32, bits per lane
- `BUFFER_SIZE`, 16, stored vectors; power of two, at least 2
- `clk` input 1 — single clock; all logic on posedge
- `reset` input 1 — synchronous, active-high
- `tracing` input 1 — recording enable; also gates dump requests
- `valid_in` input 1 — a packed vector is present on `vector_in`
- `vector_in` input [DATA_WIDTH-1:0] x N — packed vector from the packer
- `dump_req` input 1 — single-cycle pulse requesting readout
- `out_ready` input 1 — consumer accepts the current beat
- `vector_out` output [DATA_WIDTH-1:0] x N — readout vector
- `out_valid` output 1 — `vector_out` holds a valid beat
- `out_last` output 1 — current beat is the final stored vector
- `dump_done` output 1 — single-cycle pulse when a dump finishes
- `count` output [$clog2(BUFFER_SIZE):0] — number of vectors stored
- `full` output 1 — `count == BUFFER_SIZE`

## Operation
- FSM states: IDLE, DUMP, DONE.
- IDLE: a write occurs when `valid_in && tracing`. The vector is stored at `wr_ptr`, and `wr_ptr` increments modulo BUFFER_SIZE. `count` increments and saturates at BUFFER_SIZE.
- Full behaviour depends on `TRACE_BUFFER_WRAP_EN` (see Configuration).
- Dump request in IDLE:
  - `dump_req && !tracing` with `count > 0`: go to DUMP and set `rd_ptr = wr_ptr - count` (mod BUFFER_SIZE), the oldest entry.
  - `dump_req && !tracing` with `count == 0`: go to DONE directly; no data beats are produced.
  - `dump_req` while `tracing == 1`: ignored.
- DUMP:
  - `out_valid = 1`, `vector_out = mem[rd_ptr]`, `out_last = (remaining == 1)`.
  - On `out_valid && out_ready`: `rd_ptr` increments (wrapping) and `remaining` decrements.
  - The beat with `out_last` set moves the FSM to DONE.
  - Writes are blocked in DUMP regardless of `tracing`/`valid_in`; dropped inputs are not queued.
  - `dump_req` in DUMP is ignored.
- DONE: `dump_done = 1` for one cycle, `count` clears to 0, `wr_ptr` clears to 0, then return to IDLE.
- `vector_out`, `out_last`, and `rd_ptr` are stable while `out_valid && !out_ready`.

## Timing
- Reset values: `vector_out` all 0; `out_valid`, `out_last`, `dump_done`, `full` all 0; `count` 0; FSM in IDLE; pointers 0. Memory contents are not reset.
- Reset has priority over every other input. Reset during DUMP aborts the dump with no `dump_done` pulse and discards all stored data.
- Write latency: a vector accepted at edge k is reflected in `count`/`full` after edge k.
- Dump start: `dump_req` sampled at edge k gives `out_valid = 1` and the oldest vector on `vector_out` after edge k.
- Beat rate: with `out_ready` held at 1, one beat per cycle. `count == C` produces exactly C beats.
- Dump end: the last handshake at edge j gives `dump_done = 1` after edge j, and `out_valid = 0` in that same cycle.
- Empty dump: `dump_req` at edge k gives `dump_done` after edge k, and `out_valid` never rises.
- Simultaneous events:
  - `valid_in && tracing` together with `dump_req` in IDLE: the write happens and the dump is ignored, since `tracing` is high.
  - A write on the same edge the FSM enters DUMP cannot occur, because entering DUMP requires `tracing == 0`.

## Configuration
- Macro: `TRACE_BUFFER_WRAP_EN`.
- Defined: circular overwrite.
  - A write when full overwrites the oldest entry; `count` stays at BUFFER_SIZE.
  - A dump returns the most recent BUFFER_SIZE vectors.
- Undefined: stop-when-full.
  - Writes while `full` are dropped and `wr_ptr` does not advance.
  - A dump returns the first BUFFER_SIZE vectors captured.

## Structure
- Shared package `trace_pkg`:
  - FSM state enum `trace_buf_state_t` (IDLE, DUMP, DONE).
  - Localparam for the pointer width.
- Sub-module `trace_mem`: a simple dual-port register array, BUFFER_SIZE x N x DATA_WIDTH, with one synchronous write port and one combinational read port. It contains no reset logic.
- The FSM, pointers, and counters live in `trace_buffer`.

## Test plan
- Fill below capacity: 5 writes of lane value 0x10+i with tracing=1, then tracing=0 and a `dump_req` pulse, `out_ready=1` -> 5 beats 0x10..0x14 in order, `out_last` on 0x14, `dump_done` on the next cycle, `count` returns to 0.
- Wrap (WRAP_EN defined, BUFFER_SIZE=16): 20 writes of values 0..19, then dump -> 16 beats 4..19, `full=1` before the dump.
- No wrap (macro undefined): same 20 writes -> 16 beats 0..15; writes 16..19 dropped; `count=16` throughout.
- Backpressure: toggle `out_ready` 1,0,0,1 during a 3-entry dump -> `vector_out` held stable while stalled, exactly 3 handshakes, no duplicate or skipped beat.
- Corner requests: `dump_req` with tracing=1 -> ignored, `count` unchanged; `dump_req` on an empty buffer -> `dump_done` next cycle with no `out_valid`.
- Reset mid-dump: assert `reset` after the 2nd of 6 beats -> after the edge, all outputs 0, no `dump_done` pulse; a subsequent dump is empty.
